// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store ports, the port arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the environment (CPU ports plus memory).
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_req;
    logic [XLEN-1:0] i_adr;
    logic [XLEN-1:0] i_resp;
    logic            i_ack;
    logic            d_r_v;
    logic            d_w_v;
    logic [XLEN-1:0] d_adr;
    logic [XLEN-1:0] d_data;
    logic [3:0]      d_strobe;
    logic [XLEN-1:0] d_resp;
    logic            d_ack;
    logic            m_r_v;
    logic            m_w_v;
    logic [XLEN-1:0] m_adr;
    logic [XLEN-1:0] m_data;
    logic [3:0]      m_strobe;
    logic [XLEN-1:0] m_resp;
    logic            m_ack;
    logic            err;

    modport master (
        output i_req, i_adr, d_r_v, d_w_v, d_adr, d_data, d_strobe, m_resp, m_ack,
        input  i_resp, i_ack, d_resp, d_ack, m_r_v, m_w_v, m_adr, m_data, m_strobe, err
    );

    modport slave (
        input  i_req, i_adr, d_r_v, d_w_v, d_adr, d_data, d_strobe, m_resp, m_ack,
        output i_resp, i_ack, d_resp, d_ack, m_r_v, m_w_v, m_adr, m_data, m_strobe, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one request/ack memory between the instruction-fetch and load/store ports,
// with data-burst limiting and a hung-memory timeout. MEM_ARB_PERF_EN adds perf counters.
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int MAX_D_BURST    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_i_grants,
    output logic [31:0]        perf_d_grants,
    output logic [31:0]        perf_stall_cycles
`endif
);
    localparam int BW = $clog2(MAX_D_BURST + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0]   MAX_BURST_C = BW'(MAX_D_BURST);
    localparam logic [BW-1:0]   BURST_ONE_C = BW'(1);
    localparam logic [TW-1:0]   TMO_LAST_C  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   TMO_ONE_C   = TW'(1);
    localparam logic [XLEN-1:0] TMO_RESP_C  = XLEN'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_e;

    state_e          state_q;
    logic [BW-1:0]   burst_q;
    logic [TW-1:0]   tmo_q;
    logic            req_rv_q;
    logic            req_wv_q;
    logic [XLEN-1:0] req_adr_q;
    logic [XLEN-1:0] req_data_q;
    logic [3:0]      req_strobe_q;
    logic [XLEN-1:0] i_resp_q;
    logic            i_ack_q;
    logic [XLEN-1:0] d_resp_q;
    logic            d_ack_q;
    logic            err_q;

    logic d_req_s;
    logic d_grant_s;
    logic i_grant_s;
    logic busy_s;
    logic done_s;

    // A saturated burst counter yields to a pending fetch so it cannot starve.
    assign d_req_s   = bus.d_r_v | bus.d_w_v;
    assign d_grant_s = (state_q == ST_IDLE) && d_req_s && ((burst_q < MAX_BURST_C) || !bus.i_req);
    assign i_grant_s = (state_q == ST_IDLE) && bus.i_req && !d_grant_s;
    assign busy_s    = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
    assign done_s    = busy_s && (bus.m_ack || (tmo_q == TMO_LAST_C));

    // Arbitration FSM with request register, response registers and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            burst_q      <= '0;
            tmo_q        <= '0;
            req_rv_q     <= 1'b0;
            req_wv_q     <= 1'b0;
            req_adr_q    <= '0;
            req_data_q   <= '0;
            req_strobe_q <= 4'h0;
            i_resp_q     <= '0;
            i_ack_q      <= 1'b0;
            d_resp_q     <= '0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tmo_q <= '0;
                    if (d_grant_s) begin
                        req_adr_q    <= bus.d_adr;
                        req_data_q   <= bus.d_data;
                        req_strobe_q <= bus.d_strobe;
                        req_wv_q     <= bus.d_w_v;
                        req_rv_q     <= bus.d_r_v & ~bus.d_w_v;
                        state_q      <= ST_BUSY_D;
                        if (bus.i_req && (burst_q != MAX_BURST_C)) begin
                            burst_q <= burst_q + BURST_ONE_C;
                        end
                    end else if (i_grant_s) begin
                        req_adr_q    <= bus.i_adr;
                        req_data_q   <= '0;
                        req_strobe_q <= 4'h0;
                        req_wv_q     <= 1'b0;
                        req_rv_q     <= 1'b1;
                        burst_q      <= '0;
                        state_q      <= ST_BUSY_I;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (done_s) begin
                        req_rv_q <= 1'b0;
                        req_wv_q <= 1'b0;
                        tmo_q    <= '0;
                        state_q  <= ST_IDLE;
                        err_q    <= ~bus.m_ack;
                        if (state_q == ST_BUSY_I) begin
                            i_resp_q <= bus.m_ack ? bus.m_resp : TMO_RESP_C;
                            i_ack_q  <= 1'b1;
                        end else begin
                            d_resp_q <= bus.m_ack ? bus.m_resp : TMO_RESP_C;
                            d_ack_q  <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE_C;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    req_rv_q <= 1'b0;
                    req_wv_q <= 1'b0;
                    tmo_q    <= '0;
                end
            endcase
        end
    end

    assign bus.m_r_v    = req_rv_q;
    assign bus.m_w_v    = req_wv_q;
    assign bus.m_adr    = req_adr_q;
    assign bus.m_data   = req_data_q;
    assign bus.m_strobe = req_strobe_q;
    assign bus.i_resp   = i_resp_q;
    assign bus.i_ack    = i_ack_q;
    assign bus.d_resp   = d_resp_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.err      = err_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_q;
    logic [31:0] perf_d_q;
    logic [31:0] perf_stall_q;
    logic        i_wait_s;
    logic        d_wait_s;

    // A port stalls while it requests but is neither granted nor being served.
    assign i_wait_s = bus.i_req && (state_q != ST_BUSY_I) && !i_grant_s;
    assign d_wait_s = d_req_s && (state_q != ST_BUSY_D) && !d_grant_s;

    // Grant and stall counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_q     <= 32'd0;
            perf_d_q     <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (i_grant_s) perf_i_q <= perf_i_q + 32'd1;
            if (d_grant_s) perf_d_q <= perf_d_q + 32'd1;
            if (i_wait_s || d_wait_s) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_i_grants     = perf_i_q;
    assign perf_d_grants     = perf_d_q;
    assign perf_stall_cycles = perf_stall_q;
`endif
endmodule
